// File: rtl/rv_imm_stage.sv
// rv_imm_stage -- decode-side stage: fetch -> immediate generator -> execute.
//
// Each instruction/PC pair accepted from fetch is decoded on the input path
// into a 64-bit sign-extended immediate and a 3-bit format code. The result
// goes into a two-entry skid buffer (main = head, skid = second). Because of
// the skid buffer, in_ready_o can be a flop and still sustain one transfer
// per cycle.
//
// Optional feature macro: RV_IMM_STAGE_JALR_EN
//   defined   : JALR (opcode 1100111) is decoded as I-format.
//   undefined : JALR is treated as an unmapped opcode (fmt 0, imm 0).
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush, drops all buffered entries
//   in_valid_i   fetch presents an instruction
//   in_ready_o   stage can accept (registered)
//   in_instr_i   instruction word
//   in_pc_i      instruction PC
//   out_valid_o  head entry valid
//   out_ready_i  execute consumes head entry
//   out_instr_o  head instruction
//   out_pc_o     head PC
//   out_imm_o    head immediate (B/J in halfword units, unshifted)
//   out_fmt_o    head format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J

module rv_imm_gen (
  input  logic        [31:0] i_instr,
  output logic signed [63:0] o_imm,
  output logic        [2:0]  o_fmt
);

  function automatic logic signed [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  function automatic logic signed [63:0] sext20(input logic [19:0] v);
    return {{44{v[19]}}, v};
  endfunction

  function automatic logic signed [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  always_comb begin
    o_imm = '0;
    o_fmt = 3'd0;
    case (i_instr[6:0])
      7'b0000011, 7'b0010011: begin
        o_fmt = 3'd1;
        o_imm = sext12(i_instr[31:20]);
      end
      7'b0100011: begin
        o_fmt = 3'd2;
        o_imm = sext12({i_instr[31:25], i_instr[11:7]});
      end
      7'b1100011: begin
        // Halfword units: bit 0 of the byte offset is implicit.
        o_fmt = 3'd3;
        o_imm = sext12({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]});
      end
      7'b0110111, 7'b0010111: begin
        o_fmt = 3'd4;
        o_imm = sext32({i_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        o_fmt = 3'd5;
        o_imm = sext20({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21]});
      end
      default: begin
        o_fmt = 3'd0;
        o_imm = '0;
      end
    endcase
  end

endmodule

module rv_imm_stage #(
  parameter int PC_W = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [PC_W-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_instr_o,
  output logic [PC_W-1:0] out_pc_o,
  output logic [63:0]     out_imm_o,
  output logic [2:0]      out_fmt_o
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_in_ready;

  logic w_acc;
  logic w_pop;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  logic signed [63:0] w_gen_imm;
  logic        [2:0]  w_gen_fmt;
  logic signed [63:0] w_imm_p0;
  logic        [2:0]  w_fmt_p0;

  logic        [31:0]     r_main_instr_p1;
  logic        [PC_W-1:0] r_main_pc_p1;
  logic signed [63:0]     r_main_imm_p1;
  logic        [2:0]      r_main_fmt_p1;

  logic        [31:0]     r_skid_instr_p1;
  logic        [PC_W-1:0] r_skid_pc_p1;
  logic signed [63:0]     r_skid_imm_p1;
  logic        [2:0]      r_skid_fmt_p1;

  // ---- stage p0: decode on the input path ----
  rv_imm_gen u_gen (
    .i_instr (in_instr_i),
    .o_imm   (w_gen_imm),
    .o_fmt   (w_gen_fmt)
  );

`ifdef RV_IMM_STAGE_JALR_EN
  // The generator has no JALR mapping; the stage supplies the I-format result.
  always_comb begin
    w_imm_p0 = w_gen_imm;
    w_fmt_p0 = w_gen_fmt;
    if (in_instr_i[6:0] == 7'b1100111) begin
      w_fmt_p0 = 3'd1;
      w_imm_p0 = {{52{in_instr_i[31]}}, in_instr_i[31:20]};
    end
  end
`else
  assign w_imm_p0 = w_gen_imm;
  assign w_fmt_p0 = w_gen_fmt;
`endif

  assign w_acc = in_valid_i & r_in_ready;
  assign w_pop = (r_state != S_EMPTY) & out_ready_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_state_nxt    = S_ONE;
            w_load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && w_pop) begin
            w_load_main_in = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_state_nxt      = S_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // ---- stage p1: main (head) and skid registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_instr_p1 <= '0;
      r_main_pc_p1    <= '0;
      r_main_imm_p1   <= '0;
      r_main_fmt_p1   <= '0;
    end else if (!flush_i) begin
      if (w_load_main_in) begin
        r_main_instr_p1 <= in_instr_i;
        r_main_pc_p1    <= in_pc_i;
        r_main_imm_p1   <= w_imm_p0;
        r_main_fmt_p1   <= w_fmt_p0;
      end else if (w_load_main_skid) begin
        r_main_instr_p1 <= r_skid_instr_p1;
        r_main_pc_p1    <= r_skid_pc_p1;
        r_main_imm_p1   <= r_skid_imm_p1;
        r_main_fmt_p1   <= r_skid_fmt_p1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_load_skid) begin
      r_skid_instr_p1 <= in_instr_i;
      r_skid_pc_p1    <= in_pc_i;
      r_skid_imm_p1   <= w_imm_p0;
      r_skid_fmt_p1   <= w_fmt_p0;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = (r_state != S_EMPTY);
  assign out_instr_o = r_main_instr_p1;
  assign out_pc_o    = r_main_pc_p1;
  assign out_imm_o   = r_main_imm_p1;
  assign out_fmt_o   = r_main_fmt_p1;

endmodule

// File: tb/tb_rv_imm_stage.sv
module tb_rv_imm_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;

  int n_checks = 0;
  int n_errors = 0;

  rv_imm_stage #(.PC_W(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_instr_i  (in_instr),
    .in_pc_i     (in_pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .out_pc_o    (out_pc),
    .out_imm_o   (out_imm),
    .out_fmt_o   (out_fmt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t q[$];
  bit     m_ready = 0;

  function automatic longint sgn(input longint v, input int bits);
    longint half = longint'(1) <<< (bits - 1);
    if (v >= half) return v - (half * 2);
    return v;
  endfunction

  function automatic int ref_fmt(input logic [31:0] ins);
    int op = int'(ins & 32'h7f);
    case (op)
      'h03, 'h13: return 1;
      'h23:       return 2;
      'h63:       return 3;
      'h37, 'h17: return 4;
      'h6f:       return 5;
`ifdef RV_IMM_STAGE_JALR_EN
      'h67:       return 1;
`endif
      default:    return 0;
    endcase
  endfunction

  function automatic longint ref_imm(input logic [31:0] ins);
    longint u = longint'(ins);
    case (ref_fmt(ins))
      1: return sgn(u >> 20, 12);
      2: return sgn(((u >> 25) * 32) + ((u >> 7) & 31), 12);
      3: return sgn(((u >> 31) & 1) * 2048 + ((u >> 7) & 1) * 1024
                    + ((u >> 25) & 63) * 16 + ((u >> 8) & 15), 12);
      4: return sgn(u & 64'hFFFFF000, 32);
      5: return sgn(((u >> 31) & 1) * 524288 + ((u >> 12) & 255) * 2048
                    + ((u >> 20) & 1) * 1024 + ((u >> 21) & 1023), 20);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ready = 0;
    end else begin
      bit acc;
      bit pop;
      acc = in_valid && m_ready;
      pop = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{instr: in_instr, pc: in_pc});
      end
      m_ready = (q.size() != 2);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm", out_imm, ref_imm(q[0].instr));
      chk("out_fmt", {61'd0, out_fmt}, 64'(ref_fmt(q[0].instr)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h33};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    // Reset state.
    step();
    step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
    rst = 1'b0;
    chk("ready_before_edge", {63'd0, in_ready}, 64'd0);
    step();
    chk("ready_after_release", {63'd0, in_ready}, 64'd1);

    // addi x1,x0,-1
    in_valid = 1; in_instr = 32'hFFF00093; in_pc = 64'h1000;
    step();
    in_valid = 0;
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_fmt", {61'd0, out_fmt}, 64'd1);
    chk("addi_pc", out_pc, 64'h1000);
    out_ready = 1;
    step();

    // lui then beq back-to-back
    in_valid = 1; in_instr = 32'h12345037; in_pc = 64'h2000;
    step();
    chk("lui_imm", out_imm, 64'h0000_0000_1234_5000);
    chk("lui_fmt", {61'd0, out_fmt}, 64'd4);
    in_instr = 32'hFE000EE3; in_pc = 64'h2004;
    step();
    in_valid = 0;
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("beq_fmt", {61'd0, out_fmt}, 64'd3);
    step();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // Back-pressure with three offers.
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00100113; in_pc = 64'h3000;   // A
    step();
    in_instr = 32'h00200193; in_pc = 64'h3004;                 // B
    step();
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    in_instr = 32'h00300213; in_pc = 64'h3008;                 // C
    step();
    chk("hold_A", {32'd0, out_instr}, 64'h00100113);
    out_ready = 1;
    step();
    chk("order_B", {32'd0, out_instr}, 64'h00200193);
    chk("ready_after_pop", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 0;
    chk("order_C", {32'd0, out_instr}, 64'h00300213);
    step();
    chk("empty_after_C", {63'd0, out_valid}, 64'd0);

    // Flush while FULL, with a simultaneous offer.
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00400293; in_pc = 64'h4000;
    step();
    in_pc = 64'h4004;
    step();
    flush = 1; in_pc = 64'h4008;
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1;
    repeat (3) step();

    // jalr
    in_valid = 1; in_instr = 32'hFFC08067; in_pc = 64'h5000;
    step();
    in_valid = 0;
`ifdef RV_IMM_STAGE_JALR_EN
    chk("jalr_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jalr_fmt", {61'd0, out_fmt}, 64'd1);
`else
    chk("jalr_imm", out_imm, 64'd0);
    chk("jalr_fmt", {61'd0, out_fmt}, 64'd0);
`endif
    step();

    // Asynchronous reset while FULL.
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00500313; in_pc = 64'h6000;
    step();
    step();
    in_valid = 0;
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready}, 64'd0);
    step();
    rst = 0;
    step();
    chk("rst_release_ready", {63'd0, in_ready}, 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
